// File: rtl/npu_mem_pkg.sv
// npu_mem_pkg: shared memory-block types and address-width helper.
// Contents: state_t (IDLE/CLEAR sweep states), addr_width() = max(1, ceil(log2(depth))).
package npu_mem_pkg;
   typedef enum logic {IDLE, CLEAR} state_t;
   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction
endpackage

// File: rtl/sram_core_masked.sv
// sram_core_masked: word array with per-lane masked write and combinational read.
// Ports: clk; we/wa/wd/wm write port (wm bit i enables lane i of wd);
//        ra/rd read port. Out-of-range addresses drop writes and read as zero.
module sram_core_masked import npu_mem_pkg::*; #(
   parameter int WIDTH = 160,
   parameter int DEPTH = 16,
   parameter int LANES = 16,
   localparam int AW = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [LANES-1:0] wm,
   input  logic [AW-1:0]    ra,
   output logic [WIDTH-1:0] rd
);
   localparam int LW = WIDTH / LANES;
   localparam logic [AW:0] DW = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   // contents are deliberately never reset so the array maps onto an SRAM macro
   always_ff @(posedge clk)
      if (we && {1'b0, wa} < DW)
         for (int i = 0; i < LANES; i++)
            if (wm[i]) mem[wa][i*LW +: LW] <= wd[i*LW +: LW];
   assign rd = ({1'b0, ra} < DW) ? mem[ra] : '0;
endmodule

// File: rtl/sram_param_masked.sv
// sram_param_masked: single-port masked-write SRAM with clear sweep and optional output register.
// Ports: clk, reset (async, active-high); CEN (active-low enable), WEN (1=read, 0=write),
//        A address, D write data, M lane mask; clr_req starts a zeroing sweep;
//        Q read data, q_valid one-cycle new-data pulse, busy high during the sweep.
module sram_param_masked import npu_mem_pkg::*; #(
   parameter int WIDTH   = 160,
   parameter int DEPTH   = 16,
   parameter int LANES   = 16,
   parameter int OUT_REG = 0,
   localparam int AW = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             CEN,
   input  logic             WEN,
   input  logic [AW-1:0]    A,
   input  logic [WIDTH-1:0] D,
   input  logic [LANES-1:0] M,
   input  logic             clr_req,
   output logic [WIDTH-1:0] Q,
   output logic             q_valid,
   output logic             busy
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   state_t state;
   logic [AW-1:0] cnt;
   logic [WIDTH-1:0] rdata, dreg;
   logic dvalid, sweep, acc;
   assign sweep = state == CLEAR;
   // clr_req wins over a same-cycle access, which is then dropped
   assign acc = state == IDLE && !clr_req && !CEN;
   assign busy = sweep;
   sram_core_masked #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) core (
      .clk(clk),
      .we(!reset && (sweep || (acc && !WEN))),
      .wa(sweep ? cnt : A),
      .wd(sweep ? '0 : D),
      .wm(sweep ? '1 : M),
      .ra(A),
      .rd(rdata)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         dreg   <= '0;
         dvalid <= 1'b0;
      end else begin
         dvalid <= acc && WEN;
         if (acc && WEN) dreg <= rdata;
         if (state == IDLE) begin
            if (clr_req) begin
               state <= CLEAR;
               cnt   <= '0;
            end
         end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= IDLE;
         end
      end
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [WIDTH-1:0] qreg;
         logic qv;
         // runs independently of the FSM so in-flight reads finish across a sweep
         always_ff @(posedge clk or posedge reset)
            if (reset) begin
               qreg <= '0;
               qv   <= 1'b0;
            end else begin
               qv <= dvalid;
               if (dvalid) qreg <= dreg;
            end
         assign Q = qreg;
         assign q_valid = qv;
      end else begin : g_direct
         assign Q = dreg;
         assign q_valid = dvalid;
      end
   endgenerate
endmodule

// File: tb/tb_sram_param_masked.sv
// tb_sram_param_masked: scoreboard bench for a default instance and an OUT_REG=1, DEPTH=10 instance.
module tb_sram_param_masked;
   localparam int W = 160;
   localparam logic [W-1:0] ONES = '1;
   localparam logic [W-1:0] AA = {20{8'hAA}};
   typedef struct {logic [W-1:0] d; int c;} exp_t;
   logic clk = 1'b0, reset;
   logic cen0, wen0, clr0, qv0, busy0;
   logic [3:0] a0;
   logic [W-1:0] d0, q0;
   logic [15:0] m0;
   logic cen1, wen1, clr1, qv1, busy1;
   logic [3:0] a1;
   logic [W-1:0] d1, q1;
   logic [15:0] m1;
   exp_t sb0[$], sb1[$];
   int cyc = 0, checks = 0, passed = 0, n;
   sram_param_masked dut0 (
      .clk(clk), .reset(reset), .CEN(cen0), .WEN(wen0), .A(a0), .D(d0), .M(m0),
      .clr_req(clr0), .Q(q0), .q_valid(qv0), .busy(busy0)
   );
   sram_param_masked #(.WIDTH(160), .DEPTH(10), .LANES(16), .OUT_REG(1)) dut1 (
      .clk(clk), .reset(reset), .CEN(cen1), .WEN(wen1), .A(a1), .D(d1), .M(m1),
      .clr_req(clr1), .Q(q1), .q_valid(qv1), .busy(busy1)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic ok, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   function automatic logic [W-1:0] pat(input int k);
      logic [9:0] v;
      v = 10'(k * 37 + 5);
      return {16{v}};
   endfunction
   function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw, input logic [15:0] m);
      logic [W-1:0] r;
      r = old;
      for (int i = 0; i < 16; i++) if (m[i]) r[i*10 +: 10] = nw[i*10 +: 10];
      return r;
   endfunction
   always @(negedge clk) begin : mon
      exp_t e;
      if (qv0) begin
         if (sb0.size() == 0) chk("dut0_spurious_q_valid", 1'b0, q0, '0);
         else begin
            e = sb0.pop_front();
            chk("dut0_read_data", q0 === e.d, q0, e.d);
            chk("dut0_read_cycle", cyc == e.c, W'(cyc), W'(e.c));
         end
      end
      if (qv1) begin
         if (sb1.size() == 0) chk("dut1_spurious_q_valid", 1'b0, q1, '0);
         else begin
            e = sb1.pop_front();
            chk("dut1_read_data", q1 === e.d, q1, e.d);
            chk("dut1_read_cycle", cyc == e.c, W'(cyc), W'(e.c));
         end
      end
   end
   task automatic wr0(input logic [3:0] a, input logic [W-1:0] d, input logic [15:0] m);
      cen0 = 0; wen0 = 0; a0 = a; d0 = d; m0 = m;
      @(posedge clk); #1;
      cen0 = 1;
   endtask
   task automatic rd0(input logic [3:0] a, input logic [W-1:0] e);
      cen0 = 0; wen0 = 1; a0 = a;
      sb0.push_back('{e, cyc + 1});
      @(posedge clk); #1;
      cen0 = 1;
   endtask
   task automatic wr1(input logic [3:0] a, input logic [W-1:0] d, input logic [15:0] m);
      cen1 = 0; wen1 = 0; a1 = a; d1 = d; m1 = m;
      @(posedge clk); #1;
      cen1 = 1;
   endtask
   task automatic rd1(input logic [3:0] a, input logic [W-1:0] e);
      cen1 = 0; wen1 = 1; a1 = a;
      sb1.push_back('{e, cyc + 2});
      @(posedge clk); #1;
      cen1 = 1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      reset = 1;
      cen0 = 1; wen0 = 1; a0 = 0; d0 = '0; m0 = '0; clr0 = 0;
      cen1 = 1; wen1 = 1; a1 = 0; d1 = '0; m1 = '0; clr1 = 0;
      repeat (2) @(posedge clk); #1;
      chk("reset_q", q0 === '0, q0, '0);
      chk("reset_q_valid", qv0 === 1'b0, W'(qv0), '0);
      chk("reset_busy", busy0 === 1'b0, W'(busy0), '0);
      reset = 0;
      @(posedge clk); #1;
      wr0(3, ONES, 16'hFFFF);
      rd0(3, ONES);
      wr0(5, ONES, 16'hFFFF);
      wr0(5, '0, 16'h0001);
      rd0(5, {{150{1'b1}}, 10'b0});
      wr0(6, ONES, 16'hFFFF);
      wr0(6, pat(1), 16'hA5A5);
      rd0(6, merge(ONES, pat(1), 16'hA5A5));
      wr0(2, AA, 16'hFFFF);
      rd0(2, AA);
      wr0(2, '0, 16'hFFFF);
      chk("hold_q_after_write", q0 === AA, q0, AA);
      chk("hold_q_valid_low", qv0 === 1'b0, W'(qv0), '0);
      @(posedge clk); #1;
      chk("hold_q_idle", q0 === AA, q0, AA);
      for (int k = 0; k < 16; k++) wr0(4'(k), pat(k), 16'hFFFF);
      rd0(3, pat(3));
      cen0 = 0; wen0 = 0; a0 = 7; d0 = ONES; m0 = 16'hFFFF; clr0 = 1;
      @(posedge clk); #1;
      wen0 = 1; a0 = 1;
      n = 0;
      while (busy0 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      cen0 = 1; clr0 = 0;
      chk("clear_busy_cycles", n == 16, W'(n), W'(16));
      for (int k = 0; k < 16; k++) rd0(4'(k), '0);
      for (int k = 0; k < 16; k++) wr0(4'(k), pat(k + 3), 16'hFFFF);
      rd0(15, pat(18));
      clr0 = 1;
      @(posedge clk); #1;
      clr0 = 0;
      chk("sweep_busy_started", busy0 === 1'b1, W'(busy0), W'(1));
      repeat (4) @(posedge clk);
      #1;
      reset = 1;
      #1;
      chk("abort_busy_low", busy0 === 1'b0, W'(busy0), '0);
      chk("abort_q_zero", q0 === '0, q0, '0);
      chk("abort_q_valid_low", qv0 === 1'b0, W'(qv0), '0);
      @(posedge clk); #1;
      reset = 0;
      for (int k = 0; k < 16; k++) rd0(4'(k), (k < 4) ? '0 : pat(k + 3));
      wr1(9, pat(9), 16'hFFFF);
      wr1(12, ONES, 16'hFFFF);
      rd1(9, pat(9));
      rd1(12, '0);
      rd1(9, pat(9));
      clr1 = 1;
      @(posedge clk); #1;
      clr1 = 0;
      n = 0;
      while (busy1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      chk("dut1_clear_busy_cycles", n == 10, W'(n), W'(10));
      rd1(9, '0);
      repeat (4) @(posedge clk);
      #1;
      chk("sb0_drained", sb0.size() == 0, W'(sb0.size()), '0);
      chk("sb1_drained", sb1.size() == 0, W'(sb1.size()), '0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sram_param_masked.md
SRAM_PARAM_MASKED -- requirements
Module: sram_param_masked

Interface
REQ-001 SHALL have parameter WIDTH, default 160: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of words, 2..1024.
REQ-003 SHALL have parameter LANES, default 16: write-mask lanes; WIDTH SHALL be divisible by LANES; lane width LW = WIDTH/LANES.
REQ-004 SHALL have parameter OUT_REG, default 0: extra output register stage when 1.
REQ-005 SHALL derive AW = max(1, ceil(log2(DEPTH))).
REQ-006 clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 CEN  input  1  chip enable, active-low.
REQ-009 WEN  input  1  1 = read, 0 = write; sampled only when CEN=0.
REQ-010 A  input  AW  word address.
REQ-011 D  input  WIDTH  write data.
REQ-012 M  input  LANES  write lane mask, active-high; bit i covers D[i*LW +: LW].
REQ-013 clr_req  input  1  request to zero the whole array.
REQ-014 Q  output  WIDTH  read data.
REQ-015 q_valid  output  1  one-cycle pulse marking new data on Q.
REQ-016 busy  output  1  high while a clear sweep runs.

Function
REQ-017 Write: at an edge with CEN=0, WEN=0, busy=0, SHALL update only the lanes of word A whose M bit is 1; other lanes SHALL keep their old value.
REQ-018 Read: at an edge n with CEN=0, WEN=1, busy=0, SHALL capture word A into a data register; Q and q_valid=1 SHALL appear after edge n+OUT_REG.
REQ-019 Q SHALL hold its last read value until the next read completes; later writes to the same address SHALL NOT change Q.
REQ-020 q_valid SHALL be high for exactly one cycle per accepted read; back-to-back reads SHALL give consecutive q_valid pulses at full throughput.
REQ-021 Address A >= DEPTH: a write SHALL be ignored; a read SHALL return all-zero Q with q_valid=1.
REQ-022 State machine: IDLE and CLEAR.
REQ-023 IDLE to CLEAR: at an edge with clr_req=1 in IDLE. clr_req has priority over a CEN access in the same cycle, and that access SHALL be dropped.
REQ-024 CLEAR: SHALL write zero to word k at edge k (k = 0..DEPTH-1) using an internal counter, then return to IDLE; the sweep SHALL take exactly DEPTH cycles.
REQ-025 busy SHALL be 1 in CLEAR and 0 in IDLE; it is driven from state, with no combinational path from inputs.
REQ-026 While busy=1, SHALL ignore CEN accesses and clr_req; no q_valid pulse is produced for them.
REQ-027 A read issued in the cycle before clr_req is accepted SHALL still complete normally.
REQ-028 In-flight reads with OUT_REG=1 SHALL complete even if CLEAR starts.

Reset
REQ-029 Reset SHALL immediately force Q=0, q_valid=0, busy=0, state=IDLE, and the clear counter and pipeline registers to 0.
REQ-030 Array contents SHALL NOT be reset, which keeps the block SRAM-macro compatible; reset during CLEAR SHALL abort the sweep and leave unswept words unchanged.

Structure
REQ-031 State enum (IDLE, CLEAR) and the AW derivation function SHALL live in shared package npu_mem_pkg.
REQ-032 The storage array plus masked-write logic SHALL be one sub-module, sram_core_masked; the FSM, clear counter and output stages SHALL be in the top module.

Verification
REQ-033 Defaults: write addr 3 D=all-ones M=16'hFFFF, then read addr 3 -> Q=all-ones, q_valid pulse one cycle after the read edge.
REQ-034 Masked write: addr 5 holds all-ones; write D=0 with M=16'h0001 -> read returns all-ones except bits [9:0]=0.
REQ-035 Q hold: read addr 2 (value 0xAA..), then write addr 2 = 0 -> Q stays 0xAA.., q_valid low.
REQ-036 Clear: clr_req together with a write to addr 7 -> busy high exactly 16 cycles, write dropped, all 16 words read back 0.
REQ-037 OUT_REG=1, DEPTH=10: reads to addr 9 then addr 12 -> q_valid pulses on edges n+1 and n+2; Q = mem[9], then 0.
REQ-038 Reset asserted at sweep cycle 4 -> busy drops at once, words 0..3 = 0, words 4..15 keep prior data.
